ddc_mux_tdm_scheduler: RTL and testbench
========================================

# ddc_mux_tdm_scheduler

- Round-robin scheduler that shares the DDC serial I/Q bus (data, valid, channel index) among NUM_CH parallel DDC channel outputs.
- Sits upstream of the serial-to-parallel demux.
- Each granted channel's I/Q pair is emitted as two paced serial words.
- Valid pulses are shaped so the demux's edge-captured data and channel index are stable around both valid edges.

## Interface
Parameters:
- DATA_WIDTH, 24: sample width of I, Q and serial data.
- NUM_CH, 4: number of requesting channels, 1..8.
- VALID_HI, 2: cycles Data_Out_Valid is high per word, ≥1.
- VALID_LO, 2: cycles Data_Out_Valid is low after each word, ≥1.

Ports:
- CLK  in  1  — single clock.
- RST  in  1  — reset, synchronous, active-high.
- Ch_Valid  in  NUM_CH  — bit k set: channel k holds a sample pair.
- Ch_Data_I  in  NUM_CH*DATA_WIDTH  — channel k I sample at [k*DATA_WIDTH +: DATA_WIDTH], signed.
- Ch_Data_Q  in  NUM_CH*DATA_WIDTH  — channel k Q sample at the same slice, signed.
- Ch_Ack  out  NUM_CH  — one-hot, one-cycle pulse: pair of channel k captured.
- Sink_Full  in  1  — downstream FIFO full; blocks new grants.
- Data_Out  out  DATA_WIDTH  — serial word.
- Data_Out_Valid  out  1  — shaped valid pulse.
- Data_Out_ChIdx  out  4  — 2k for I of channel k, 2k+1 for Q.
- Grant_Ch  out  3  — channel currently being serialized.
- Busy  out  1  — burst in progress.

## Operation
- FSM states: IDLE, I_HI, I_LO, Q_HI, Q_LO. A phase counter counts down within each state. A round-robin pointer rr_ptr (0..NUM_CH-1) sets search order.
- **IDLE**
  - If Sink_Full=0 and any Ch_Valid bit is set, grant the first set bit searching rr_ptr, rr_ptr+1, … modulo NUM_CH.
  - Capture that channel's I and Q into internal registers.
  - Set rr_ptr = (k+1) mod NUM_CH and go to I_HI.
  - Otherwise stay in IDLE; Ch_Valid bits are ignored while Sink_Full=1.
- **I_HI** (VALID_HI cycles): Data_Out = captured I, Data_Out_ChIdx = 2k, Data_Out_Valid = 1. Ch_Ack[k] = 1 in the first I_HI cycle only.
- **I_LO** (VALID_LO cycles): Data_Out_Valid = 0; Data_Out and ChIdx held at their I values.
- **Q_HI** (VALID_HI cycles): Data_Out = captured Q, ChIdx = 2k+1, Valid = 1.
- **Q_LO** (VALID_LO cycles): Valid = 0, Q word held; then return to IDLE.
- Data_Out and ChIdx change only on entry to I_HI or Q_HI. They are stable for the full HI+LO window, so capture on either valid edge is safe.
- **Requester contract:** hold Ch_Valid and data until Ch_Ack. Ch_Valid of the granted channel is not re-sampled until the next IDLE. A requester drops Valid the cycle after Ack unless it has a new pair.
- Sink_Full is sampled only in IDLE. A started burst always completes both words.
- Busy = 1 in all non-IDLE states. Grant_Ch holds k from grant until the next grant.
- No arithmetic on samples: pure transfer, width-preserving.

## Timing
- Reset: Data_Out=0, Data_Out_Valid=0, Data_Out_ChIdx=0, Ch_Ack=0, Grant_Ch=0, Busy=0, rr_ptr=0, state IDLE, captured registers 0.
- Grant decided in IDLE cycle T, registered at the end of T.
- Cycle T+1: Ch_Ack[k]=1, Valid=1, ChIdx=2k, Busy=1.
- Valid high T+1 … T+VALID_HI, low for the next VALID_LO cycles.
- Q word high at T+1+VALID_HI+VALID_LO for VALID_HI cycles, then low VALID_LO cycles.
- IDLE is re-entered at T+1+2*(VALID_HI+VALID_LO). A new grant may be made in that same cycle, giving back-to-back bursts.
- Burst period is 1+2*(VALID_HI+VALID_LO) cycles; 9 with defaults.
- Reset during a burst aborts it:
  - Outputs return to reset values on the cycle after RST is sampled.
  - The acknowledged pair is lost and is not re-acked.
  - rr_ptr returns to 0.
- NUM_CH=1: pointer stays 0, channel 0 granted whenever valid.

## Test plan
- Single request: Ch_Valid=4'b0100, I=24'h123456, Q=24'hABCDEF → Ack[2] at T+1. Word 24'h123456 with ChIdx 4 is valid T+1..T+2; word 24'hABCDEF with ChIdx 5 is valid T+5..T+6. Busy falls at T+9.
- All four channels held valid → grant order 0,1,2,3,0. Bursts are back-to-back every 9 cycles and ChIdx sequence is 0,1,2,3,4,5,6,7,0,1.
- Wrap-around: grant ch3 (rr_ptr→0), then Ch_Valid=4'b1001 → ch0 granted next, not ch3.
- Back-pressure: Sink_Full=1 with Ch_Valid=4'b0001 → no Ack and Valid stays 0. Assert Sink_Full mid-burst → burst completes, next grant waits until Sink_Full=0.
- Reset mid-burst: RST in the Q_HI cycle → Valid=0, Busy=0 and ChIdx=0 the next cycle. Afterwards, Ch_Valid=4'b1111 grants ch0 first.
- VALID_HI=VALID_LO=1: burst period is 5 cycles; Valid pattern 1,0,1,0 per burst.

Source files
------------

// File: rtl/ddc_mux_tdm_scheduler_if.sv
// Bus between the DDC channel bank, the TDM scheduler and the serial I/Q demux.
// master: scheduler side; slave: the requesting channels plus the downstream sink.
interface ddc_mux_tdm_scheduler_if #(
   parameter int DATA_WIDTH = 24,
   parameter int NUM_CH     = 4
);
   logic [NUM_CH-1:0]            Ch_Valid;
   logic [NUM_CH*DATA_WIDTH-1:0] Ch_Data_I;
   logic [NUM_CH*DATA_WIDTH-1:0] Ch_Data_Q;
   logic [NUM_CH-1:0]            Ch_Ack;
   logic                         Sink_Full;
   logic [DATA_WIDTH-1:0]        Data_Out;
   logic                         Data_Out_Valid;
   logic [3:0]                   Data_Out_ChIdx;
   logic [2:0]                   Grant_Ch;
   logic                         Busy;

   modport master (
      input  Ch_Valid, Ch_Data_I, Ch_Data_Q, Sink_Full,
      output Ch_Ack, Data_Out, Data_Out_Valid, Data_Out_ChIdx, Grant_Ch, Busy
   );

   modport slave (
      output Ch_Valid, Ch_Data_I, Ch_Data_Q, Sink_Full,
      input  Ch_Ack, Data_Out, Data_Out_Valid, Data_Out_ChIdx, Grant_Ch, Busy
   );
endinterface

// File: rtl/ddc_mux_tdm_scheduler.sv
// Round-robin TDM scheduler: serializes one channel's I/Q pair per burst onto the shared
// serial bus with shaped valid pulses; data and channel index are stable across each HI+LO window.
module ddc_mux_tdm_scheduler #(
   parameter int DATA_WIDTH = 24,
   parameter int NUM_CH     = 4,
   parameter int VALID_HI   = 2,
   parameter int VALID_LO   = 2
) (
   input  logic                    CLK,
   input  logic                    RST,
   ddc_mux_tdm_scheduler_if.master bus
);
   localparam int PH_MAX = (VALID_HI > VALID_LO) ? VALID_HI : VALID_LO;
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam logic [PH_W-1:0] HI_LOAD = PH_W'(VALID_HI - 1);
   localparam logic [PH_W-1:0] LO_LOAD = PH_W'(VALID_LO - 1);

   typedef enum logic [2:0] {IDLE, I_HI, I_LO, Q_HI, Q_LO} state_t;

   state_t                 state_q, state_nxt;
   logic [PH_W-1:0]        phase_q, phase_nxt;
   logic [2:0]             rr_q, rr_nxt;
   logic [2:0]             grant_q, grant_nxt;
   logic [NUM_CH-1:0]      ack_q, ack_nxt;
   logic [DATA_WIDTH-1:0]  dout_q, dout_nxt;
   logic [3:0]             chidx_q, chidx_nxt;
   logic [DATA_WIDTH-1:0]  capq_q, capq_nxt;

   logic [7:0]             vld8;
   logic [2:0]             cand;
   logic [2:0]             pick;
   logic                   found;

   assign vld8 = 8'(bus.Ch_Valid);

   // Walk from the farthest offset down so the nearest requester to rr_q wins.
   always_comb begin
      found = 1'b0;
      pick  = 3'd0;
      cand  = 3'd0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         cand = 3'((int'(rr_q) + i) % NUM_CH);
         if (vld8[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_nxt = state_q;
      phase_nxt = phase_q;
      rr_nxt    = rr_q;
      grant_nxt = grant_q;
      ack_nxt   = '0;
      dout_nxt  = dout_q;
      chidx_nxt = chidx_q;
      capq_nxt  = capq_q;
      case (state_q)
         IDLE: begin
            if (!bus.Sink_Full && found) begin
               state_nxt = I_HI;
               phase_nxt = HI_LOAD;
               grant_nxt = pick;
               rr_nxt    = (pick == 3'(NUM_CH - 1)) ? 3'd0 : pick + 3'd1;
               ack_nxt   = NUM_CH'(1) << pick;
               dout_nxt  = bus.Ch_Data_I[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
               capq_nxt  = bus.Ch_Data_Q[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
               chidx_nxt = {pick, 1'b0};
            end
         end
         I_HI: begin
            if (phase_q == '0) begin
               state_nxt = I_LO;
               phase_nxt = LO_LOAD;
            end else begin
               phase_nxt = phase_q - PH_W'(1);
            end
         end
         I_LO: begin
            if (phase_q == '0) begin
               state_nxt = Q_HI;
               phase_nxt = HI_LOAD;
               dout_nxt  = capq_q;
               chidx_nxt = {grant_q, 1'b1};
            end else begin
               phase_nxt = phase_q - PH_W'(1);
            end
         end
         Q_HI: begin
            if (phase_q == '0) begin
               state_nxt = Q_LO;
               phase_nxt = LO_LOAD;
            end else begin
               phase_nxt = phase_q - PH_W'(1);
            end
         end
         Q_LO: begin
            if (phase_q == '0) begin
               state_nxt = IDLE;
            end else begin
               phase_nxt = phase_q - PH_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         phase_q <= '0;
         rr_q    <= 3'd0;
         grant_q <= 3'd0;
         ack_q   <= '0;
         dout_q  <= '0;
         chidx_q <= 4'd0;
         capq_q  <= '0;
      end else begin
         state_q <= state_nxt;
         phase_q <= phase_nxt;
         rr_q    <= rr_nxt;
         grant_q <= grant_nxt;
         ack_q   <= ack_nxt;
         dout_q  <= dout_nxt;
         chidx_q <= chidx_nxt;
         capq_q  <= capq_nxt;
      end
   end

   assign bus.Ch_Ack         = ack_q;
   assign bus.Data_Out       = dout_q;
   assign bus.Data_Out_Valid = (state_q == I_HI) || (state_q == Q_HI);
   assign bus.Data_Out_ChIdx = chidx_q;
   assign bus.Grant_Ch       = grant_q;
   assign bus.Busy           = (state_q != IDLE);
endmodule

// File: tb/tb_ddc_mux_tdm_scheduler.sv
// Directed bench for the TDM scheduler: default pacing instance plus a VALID_HI=VALID_LO=1 instance.
module tb_ddc_mux_tdm_scheduler;
   logic CLK = 1'b0;
   logic RST;
   int   checks = 0;
   int   fails  = 0;

   ddc_mux_tdm_scheduler_if #(.DATA_WIDTH(24), .NUM_CH(4)) bus ();
   ddc_mux_tdm_scheduler_if #(.DATA_WIDTH(24), .NUM_CH(4)) fbus ();

   ddc_mux_tdm_scheduler #(.DATA_WIDTH(24), .NUM_CH(4), .VALID_HI(2), .VALID_LO(2)) dut (
      .CLK(CLK), .RST(RST), .bus(bus.master)
   );
   ddc_mux_tdm_scheduler #(.DATA_WIDTH(24), .NUM_CH(4), .VALID_HI(1), .VALID_LO(1)) dut_fast (
      .CLK(CLK), .RST(RST), .bus(fbus.master)
   );

   always #5 CLK = ~CLK;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int g;
      RST = 1'b1;
      bus.Ch_Valid  = '0;
      bus.Ch_Data_I = '0;
      bus.Ch_Data_Q = '0;
      bus.Sink_Full = 1'b0;
      fbus.Ch_Valid  = '0;
      fbus.Ch_Data_I = '0;
      fbus.Ch_Data_Q = '0;
      fbus.Sink_Full = 1'b0;
      tick(3);
      chk("rst_valid", 32'(bus.Data_Out_Valid), 0);
      chk("rst_chidx", 32'(bus.Data_Out_ChIdx), 0);
      chk("rst_ack",   32'(bus.Ch_Ack), 0);
      chk("rst_grant", 32'(bus.Grant_Ch), 0);
      chk("rst_busy",  32'(bus.Busy), 0);
      chk("rst_data",  32'(bus.Data_Out), 0);
      RST = 1'b0;

      // single request on channel 2
      bus.Ch_Data_I[2*24 +: 24] = 24'h123456;
      bus.Ch_Data_Q[2*24 +: 24] = 24'hABCDEF;
      bus.Ch_Valid = 4'b0100;
      tick();
      chk("s_ack",   32'(bus.Ch_Ack), 32'h4);
      chk("s_valid", 32'(bus.Data_Out_Valid), 1);
      chk("s_chidx", 32'(bus.Data_Out_ChIdx), 4);
      chk("s_data",  32'(bus.Data_Out), 32'h123456);
      chk("s_busy",  32'(bus.Busy), 1);
      chk("s_grant", 32'(bus.Grant_Ch), 2);
      bus.Ch_Valid = 4'b0000;
      tick();
      chk("s_ack_t2",   32'(bus.Ch_Ack), 0);
      chk("s_valid_t2", 32'(bus.Data_Out_Valid), 1);
      tick();
      chk("s_valid_t3", 32'(bus.Data_Out_Valid), 0);
      chk("s_data_t3",  32'(bus.Data_Out), 32'h123456);
      chk("s_chidx_t3", 32'(bus.Data_Out_ChIdx), 4);
      tick(2);
      chk("s_valid_t5", 32'(bus.Data_Out_Valid), 1);
      chk("s_data_t5",  32'(bus.Data_Out), 32'hABCDEF);
      chk("s_chidx_t5", 32'(bus.Data_Out_ChIdx), 5);
      tick();
      chk("s_valid_t6", 32'(bus.Data_Out_Valid), 1);
      tick();
      chk("s_valid_t7", 32'(bus.Data_Out_Valid), 0);
      chk("s_data_t7",  32'(bus.Data_Out), 32'hABCDEF);
      tick();
      chk("s_busy_t8", 32'(bus.Busy), 1);
      tick();
      chk("s_busy_t9",  32'(bus.Busy), 0);
      chk("s_grant_t9", 32'(bus.Grant_Ch), 2);

      // wrap-around: ch3 granted, then ch0 preferred over ch3
      bus.Ch_Valid = 4'b1000;
      tick();
      chk("w_ack3",   32'(bus.Ch_Ack), 32'h8);
      chk("w_chidx6", 32'(bus.Data_Out_ChIdx), 6);
      bus.Ch_Valid = 4'b1001;
      tick(9);
      chk("w_ack0",   32'(bus.Ch_Ack), 32'h1);
      chk("w_grant0", 32'(bus.Grant_Ch), 0);
      chk("w_chidx0", 32'(bus.Data_Out_ChIdx), 0);
      bus.Ch_Valid = 4'b0000;
      tick(8);

      // reset in the first Q_HI cycle aborts the burst
      bus.Ch_Valid = 4'b0010;
      tick();
      chk("r_ack1", 32'(bus.Ch_Ack), 32'h2);
      bus.Ch_Valid = 4'b0000;
      tick(4);
      chk("r_qvalid", 32'(bus.Data_Out_Valid), 1);
      chk("r_qchidx", 32'(bus.Data_Out_ChIdx), 3);
      RST = 1'b1;
      tick();
      chk("r_valid", 32'(bus.Data_Out_Valid), 0);
      chk("r_busy",  32'(bus.Busy), 0);
      chk("r_chidx", 32'(bus.Data_Out_ChIdx), 0);
      chk("r_data",  32'(bus.Data_Out), 0);
      RST = 1'b0;

      // all four held valid: back-to-back bursts in order 0,1,2,3,0
      for (int k = 0; k < 4; k++) begin
         bus.Ch_Data_I[k*24 +: 24] = 24'h0A0000 + 24'(k);
         bus.Ch_Data_Q[k*24 +: 24] = 24'h0B0000 + 24'(k);
      end
      bus.Ch_Valid = 4'b1111;
      tick();
      for (int n = 0; n < 5; n++) begin
         g = n % 4;
         chk("rr_grant", 32'(bus.Grant_Ch), 32'(g));
         chk("rr_ack",   32'(bus.Ch_Ack), 32'(1) << g);
         chk("rr_ichidx", 32'(bus.Data_Out_ChIdx), 32'(2*g));
         chk("rr_idata", 32'(bus.Data_Out), 32'h0A0000 + 32'(g));
         tick(4);
         chk("rr_qchidx", 32'(bus.Data_Out_ChIdx), 32'(2*g + 1));
         chk("rr_qvalid", 32'(bus.Data_Out_Valid), 1);
         chk("rr_qdata", 32'(bus.Data_Out), 32'h0B0000 + 32'(g));
         tick(5);
      end

      // back-pressure asserted mid-burst (ch1 burst just started)
      bus.Ch_Valid  = 4'b0001;
      bus.Sink_Full = 1'b1;
      tick(4);
      chk("bp_qvalid", 32'(bus.Data_Out_Valid), 1);
      chk("bp_qchidx", 32'(bus.Data_Out_ChIdx), 3);
      tick(4);
      chk("bp_idle", 32'(bus.Busy), 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bp_noack",   32'(bus.Ch_Ack), 0);
         chk("bp_novalid", 32'(bus.Data_Out_Valid), 0);
      end
      bus.Sink_Full = 1'b0;
      tick();
      chk("bp_ack0",   32'(bus.Ch_Ack), 32'h1);
      chk("bp_valid",  32'(bus.Data_Out_Valid), 1);
      chk("bp_grant0", 32'(bus.Grant_Ch), 0);
      bus.Ch_Valid = 4'b0000;
      tick(8);
      chk("bp_done", 32'(bus.Busy), 0);

      // fast pacing: 5-cycle period, valid 1,0,1,0 then the IDLE grant cycle
      fbus.Ch_Data_I[0 +: 24] = 24'h111111;
      fbus.Ch_Data_Q[0 +: 24] = 24'h222222;
      fbus.Ch_Valid = 4'b0001;
      tick();
      for (int c = 0; c < 10; c++) begin
         int ph;
         ph = c % 5;
         chk("f_valid", 32'(fbus.Data_Out_Valid), (ph == 0 || ph == 2) ? 1 : 0);
         chk("f_busy",  32'(fbus.Busy), (ph == 4) ? 0 : 1);
         chk("f_ack",   32'(fbus.Ch_Ack), (ph == 0) ? 1 : 0);
         chk("f_chidx", 32'(fbus.Data_Out_ChIdx), (ph < 2) ? 0 : 1);
         chk("f_data",  32'(fbus.Data_Out), (ph < 2) ? 32'h111111 : 32'h222222);
         tick();
      end
      fbus.Ch_Valid = 4'b0000;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
